// File: rtl/mmio_uart_tx.sv
`timescale 1ns/1ps
// mmio_uart_tx
// Memory-mapped 8N1 serial transmitter on the p18240 memory bus.
// Stores to BASE_ADDR push dataBus[7:0] into a small TX FIFO. A frame
// shifter drains the FIFO onto txd. Loads from BASE_ADDR+1 return a status
// word so software can poll before writing.
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-high reset
//   memAddr    MAR contents from the datapath
//   dataBus    shared 16-bit memory data bus (driven only during status reads)
//   re_L       read enable, active-low
//   we_L       write enable, active-low
//   txd        serial output, idles high
//   txBusy     shifter is not idle
//   fifoCount  FIFO occupancy, 0..FIFO_DEPTH
//   overrun    sticky: a write was dropped because the FIFO was full
//
// Shifter states:
//   state | meaning
//   IDLE  | line high, waiting for a FIFO entry
//   START | start bit (low) for CLKS_PER_BIT cycles
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); chains straight into START if the FIFO has data
module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADDR    = 16'h2002,
    parameter logic [15:0] CLKS_PER_BIT = 16'd434,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] memAddr,
    inout  wire  [15:0] dataBus,
    input  logic        re_L,
    input  logic        we_L,
    output logic        txd,
    output logic        txBusy,
    output logic [3:0]  fifoCount,
    output logic        overrun
);

    localparam int          PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0]  DEPTH_CNT  = 4'(FIFO_DEPTH);
    localparam logic [15:0] STAT_ADDR  = BASE_ADDR + 16'd1;
    localparam logic [15:0] BIT_RELOAD = CLKS_PER_BIT - 16'd1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    state_t           state_next;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [3:0]       count;

    logic [15:0]      bit_timer;
    logic [15:0]      bit_timer_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shreg;
    logic [7:0]       shreg_next;
    logic             txd_q;
    logic             txd_next;

    logic             wr_data;
    logic             rd_stat;
    logic             empty;
    logic             full;
    logic             bit_done;
    logic             pop;
    logic             push;
    logic             drop;
    logic [15:0]      status_word;

    // The upper byte of a data store carries nothing we keep.
    logic             unused_bus_hi;
    assign unused_bus_hi = ^dataBus[15:8];

    assign wr_data  = ~we_L & (memAddr == BASE_ADDR);
    assign rd_stat  = ~re_L & we_L & (memAddr == STAT_ADDR);
    assign empty    = (count == 4'd0);
    assign full     = (count == DEPTH_CNT);
    assign bit_done = (bit_timer == 16'd0);

    // A pop happens when the shifter is ready for a new byte: straight out of
    // IDLE, or at the end of a stop bit for back-to-back frames.
    assign pop  = ~empty & ((state == IDLE) | ((state == STOP) & bit_done));
    // A pop on the same edge frees a slot, so a write while full still lands.
    assign push = wr_data & (~full | pop);
    assign drop = wr_data & full & ~pop;

    assign status_word = {9'b0, count, overrun, full, empty};
    assign dataBus     = rd_stat ? status_word : 16'bz;

    assign txd       = txd_q;
    assign txBusy    = (state != IDLE);
    assign fifoCount = count;

    // State register and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= 4'd0;
            overrun   <= 1'b0;
            bit_timer <= 16'd0;
            bit_idx   <= 3'd0;
            shreg     <= 8'd0;
            txd_q     <= 1'b1;
        end else begin
            state     <= state_next;
            bit_timer <= bit_timer_next;
            bit_idx   <= bit_idx_next;
            shreg     <= shreg_next;
            txd_q     <= txd_next;

            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase

            // A drop on the clearing edge must still leave the flag set.
            if (drop) begin
                overrun <= 1'b1;
            end else if (rd_stat) begin
                overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr] <= dataBus[7:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!empty) state_next = START;
            end
            START: begin
                if (bit_done) state_next = DATA;
            end
            DATA: begin
                if (bit_done && (bit_idx == 3'd7)) state_next = STOP;
            end
            STOP: begin
                if (bit_done) state_next = empty ? IDLE : START;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        bit_timer_next = bit_timer;
        bit_idx_next   = bit_idx;
        shreg_next     = shreg;
        case (state)
            IDLE: begin
                if (pop) begin
                    shreg_next     = fifo_mem[rd_ptr];
                    bit_timer_next = BIT_RELOAD;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_idx_next   = 3'd0;
                    bit_timer_next = BIT_RELOAD;
                end else begin
                    bit_timer_next = bit_timer - 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shreg_next     = {1'b0, shreg[7:1]};
                    bit_idx_next   = bit_idx + 3'd1;
                    bit_timer_next = BIT_RELOAD;
                end else begin
                    bit_timer_next = bit_timer - 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (pop) begin
                        shreg_next     = fifo_mem[rd_ptr];
                        bit_timer_next = BIT_RELOAD;
                    end
                end else begin
                    bit_timer_next = bit_timer - 16'd1;
                end
            end
            default: begin
                bit_timer_next = bit_timer;
            end
        endcase

        // txd is computed from what the registers will hold after the edge,
        // then registered, so the pin never sees decode glitches.
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shreg_next[0];
            default: txd_next = 1'b1;
        endcase
    end

endmodule
